// File: rtl/core_pkg.sv
// Shared core types: pipeline bus, memory-op encoding and memory-stage FSM
// states, plus small helpers that classify memory operations.
package core;

  typedef enum logic [3:0] {
    MEM_NOP,
    LB,
    LH,
    LW,
    LBU,
    LHU,
    SB,
    SH,
    SW
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP
  } mem_state_e;

  typedef struct packed {
    logic [31:0] rd_res;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    mem_op_e     mem_op;
    logic [4:0]  rd;
    logic        rf_wr_en;
  } pipeline_bus_t;

  function automatic logic is_mem(input mem_op_e op);
    return op != MEM_NOP;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] ea_lo);
    logic mis;
    case (op)
      LH, LHU, SH: mis = ea_lo[0];
      LW, SW:      mis = (ea_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Loads drive the same lane pattern as the matching store width.
  function automatic logic [3:0] access_be(input mem_op_e op, input logic [1:0] ea_lo);
    logic [3:0] be;
    case (op)
      LB, LBU, SB: be = 4'b0001 << ea_lo;
      LH, LHU, SH: be = 4'b0011 << ea_lo;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input mem_op_e op, input logic [31:0] rs2);
    logic [31:0] wd;
    case (op)
      SB:      wd = {4{rs2[7:0]}};
      SH:      wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Extracts the addressed byte/half from a loaded word and sign- or
// zero-extends it to 32 bits.
module load_formatter
  import core::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  ea_lo_i,
  input  mem_op_e     mem_op_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed lane down to bit 0; word loads are aligned so
    // their shift amount is always zero.
    shifted = rdata_i >> {ea_lo_i, 3'b000};
    case (mem_op_i)
      LB:      data_o = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     data_o = {24'h0, shifted[7:0]};
      LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: computes the effective address, runs a
// single-outstanding req/gnt/rvalid data-memory port and registers the bus.
module mem_stage
  import core::*;
(
  input  logic          clk,
  input  logic          rst,
  input  pipeline_bus_t mem_bus_i,
  input  logic          valid_i,
  output logic          stall_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [31:0]   dmem_addr_o,
  output logic [3:0]    dmem_be_o,
  output logic [31:0]   dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i,
  output pipeline_bus_t mem_bus_o,
  output logic          valid_o,
  output logic          misaligned_o
);

  mem_state_e    state_q, state_d;
  pipeline_bus_t bus_q, bus_d;
  pipeline_bus_t out_bus_q, out_bus_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [1:0]    ea_lo_q, ea_lo_d;
  logic          we_q, we_d;
  logic          valid_q, valid_d;
  logic          mis_q, mis_d;

  logic [31:0]   ea;
  logic [31:0]   load_data;

  assign ea = mem_bus_i.rs1_data + mem_bus_i.imm;

  load_formatter u_load_formatter (
    .rdata_i  (dmem_rdata_i),
    .ea_lo_i  (ea_lo_q),
    .mem_op_i (bus_q.mem_op),
    .data_o   (load_data)
  );

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d   = state_q;
    bus_d     = bus_q;
    out_bus_d = out_bus_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ea_lo_d   = ea_lo_q;
    we_d      = we_q;
    valid_d   = 1'b0;
    mis_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (!is_mem(mem_bus_i.mem_op)) begin
            out_bus_d = mem_bus_i;
            valid_d   = 1'b1;
          end else if (is_misaligned(mem_bus_i.mem_op, ea[1:0])) begin
            out_bus_d          = mem_bus_i;
            out_bus_d.rf_wr_en = 1'b0;
            valid_d            = 1'b1;
            mis_d              = 1'b1;
          end else begin
            bus_d   = mem_bus_i;
            addr_d  = {ea[31:2], 2'b00};
            ea_lo_d = ea[1:0];
            be_d    = access_be(mem_bus_i.mem_op, ea[1:0]);
            wdata_d = store_wdata(mem_bus_i.mem_op, mem_bus_i.rs2_data);
            we_d    = is_store(mem_bus_i.mem_op);
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          if (we_q) begin
            out_bus_d          = bus_q;
            out_bus_d.rf_wr_en = 1'b0;
            valid_d            = 1'b1;
            state_d            = IDLE;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (dmem_rvalid_i) begin
          out_bus_d        = bus_q;
          out_bus_d.rd_res = load_data;
          valid_d          = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bus_q     <= '0;
      out_bus_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      ea_lo_q   <= '0;
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      out_bus_q <= out_bus_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      ea_lo_q   <= ea_lo_d;
      we_q      <= we_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
    end
  end

  assign stall_o      = (state_q != IDLE);
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign mem_bus_o    = out_bus_q;
  assign valid_o      = valid_q;
  assign misaligned_o = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by randomized
// transactions checked against an arithmetic reference model.
module tb_mem_stage;
  import core::*;

  logic          clk = 1'b0;
  logic          rst;
  pipeline_bus_t mem_bus_i;
  logic          valid_i;
  logic          stall_o;
  logic          dmem_req_o;
  logic          dmem_we_o;
  logic [31:0]   dmem_addr_o;
  logic [3:0]    dmem_be_o;
  logic [31:0]   dmem_wdata_o;
  logic          dmem_gnt_i;
  logic          dmem_rvalid_i;
  logic [31:0]   dmem_rdata_i;
  pipeline_bus_t mem_bus_o;
  logic          valid_o;
  logic          misaligned_o;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .mem_bus_i     (mem_bus_i),
    .valid_i       (valid_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .mem_bus_o     (mem_bus_o),
    .valid_o       (valid_o),
    .misaligned_o  (misaligned_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on byte offsets and lane values.
  function automatic logic [31:0] model_load(input mem_op_e op, input logic [31:0] word,
                                             input int unsigned off);
    int unsigned b;
    int unsigned h;
    b = (word >> (8 * off)) % 256;
    h = (word >> (8 * off)) % 65536;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_be(input mem_op_e op, input int unsigned off);
    case (op)
      SB:      return 32'(1 << off);
      SH:      return 32'(3 << off);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input mem_op_e op, input logic [31:0] rs2);
    case (op)
      SB:      return (rs2 % 256) * 32'h0101_0101;
      SH:      return (rs2 % 65536) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic bit model_mis(input mem_op_e op, input int unsigned off);
    if (op == LH || op == LHU || op == SH) return (off % 2) != 0;
    if (op == LW || op == SW) return off != 0;
    return 1'b0;
  endfunction

  function automatic bit model_store(input mem_op_e op);
    return op == SB || op == SH || op == SW;
  endfunction

  // Issues one instruction and checks every cycle until its valid_o pulse.
  task automatic run_txn(input mem_op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] alu, input logic [4:0] rd,
                         input logic wr, input logic [31:0] word, input int gw, input int rw);
    logic [31:0]  ea;
    int unsigned  off;
    bit           mis;
    ea  = rs1 + imm;
    off = ea % 4;
    mis = model_mis(op, off);
    mem_bus_i.rd_res   = alu;
    mem_bus_i.rs1_data = rs1;
    mem_bus_i.rs2_data = rs2;
    mem_bus_i.imm      = imm;
    mem_bus_i.mem_op   = op;
    mem_bus_i.rd       = rd;
    mem_bus_i.rf_wr_en = wr;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    if (op == MEM_NOP || mis) begin
      check("direct_valid", 32'(valid_o), 32'd1);
      check("direct_mis", 32'(misaligned_o), 32'(mis));
      check("direct_req", 32'(dmem_req_o), 32'd0);
      check("direct_stall", 32'(stall_o), 32'd0);
      check("direct_wr_en", 32'(mem_bus_o.rf_wr_en), mis ? 32'd0 : 32'(wr));
      check("direct_rd", 32'(mem_bus_o.rd), 32'(rd));
      if (!mis) check("alu_rd_res", mem_bus_o.rd_res, alu);
    end else begin
      check("req_asserted", 32'(dmem_req_o), 32'd1);
      check("req_stall", 32'(stall_o), 32'd1);
      check("req_valid_low", 32'(valid_o), 32'd0);
      check("req_we", 32'(dmem_we_o), 32'(model_store(op)));
      check("req_addr", dmem_addr_o, ea - off);
      if (model_store(op)) begin
        check("req_be", 32'(dmem_be_o), model_be(op, off));
        check("req_wdata", dmem_wdata_o, model_wdata(op, rs2));
      end
      for (int i = 0; i < gw; i++) begin
        step();
        check("hold_req", 32'(dmem_req_o), 32'd1);
        check("hold_addr", dmem_addr_o, ea - off);
        check("hold_stall", 32'(stall_o), 32'd1);
        if (model_store(op)) check("hold_be", 32'(dmem_be_o), model_be(op, off));
      end
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      if (model_store(op)) begin
        check("st_valid", 32'(valid_o), 32'd1);
        check("st_wr_en", 32'(mem_bus_o.rf_wr_en), 32'd0);
        check("st_mis", 32'(misaligned_o), 32'd0);
        check("st_stall", 32'(stall_o), 32'd0);
        check("st_req", 32'(dmem_req_o), 32'd0);
      end else begin
        check("wait_stall", 32'(stall_o), 32'd1);
        check("wait_req", 32'(dmem_req_o), 32'd0);
        check("wait_valid", 32'(valid_o), 32'd0);
        for (int i = 0; i < rw; i++) begin
          dmem_rdata_i = $urandom;
          step();
          check("wait_hold_stall", 32'(stall_o), 32'd1);
          check("wait_hold_valid", 32'(valid_o), 32'd0);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = word;
        step();
        dmem_rvalid_i = 1'b0;
        check("ld_valid", 32'(valid_o), 32'd1);
        check("ld_rd_res", mem_bus_o.rd_res, model_load(op, word, off));
        check("ld_wr_en", 32'(mem_bus_o.rf_wr_en), 32'(wr));
        check("ld_rd", 32'(mem_bus_o.rd), 32'(rd));
        check("ld_mis", 32'(misaligned_o), 32'd0);
        check("ld_stall", 32'(stall_o), 32'd0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_mis"}, 32'(misaligned_o), 32'd0);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_req"}, 32'(dmem_req_o), 32'd0);
    check({tag, "_we"}, 32'(dmem_we_o), 32'd0);
    check({tag, "_addr"}, dmem_addr_o, 32'd0);
    check({tag, "_be"}, 32'(dmem_be_o), 32'd0);
    check({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    check({tag, "_rd_res"}, mem_bus_o.rd_res, 32'd0);
    check({tag, "_wr_en"}, 32'(mem_bus_o.rf_wr_en), 32'd0);
  endtask

  mem_op_e ops [9] = '{MEM_NOP, LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    rst           = 1'b1;
    valid_i       = 1'b0;
    mem_bus_i     = '0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    repeat (3) step();
    rst = 1'b0;
    check_all_zero("reset");

    // ADD pass-through, then back-to-back ALU ops
    run_txn(MEM_NOP, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 32'h0, 0, 0);
    run_txn(MEM_NOP, 32'h0, 32'h0, 32'h0, 32'hCAFE_0001, 5'd6, 1'b1, 32'h0, 0, 0);
    // SW with zero-wait grant
    run_txn(SW, 32'h100, 32'hDEAD_BEEF, 32'd4, 32'h0, 5'd0, 1'b0, 32'h0, 0, 0);
    // LB / LBU at ea 0x203
    run_txn(LB, 32'h200, 32'h0, 32'd3, 32'h0, 5'd7, 1'b1, 32'h80FF_0011, 0, 0);
    run_txn(LBU, 32'h200, 32'h0, 32'd3, 32'h0, 5'd8, 1'b1, 32'h80FF_0011, 0, 0);
    // SH at ea 0x102 with grant withheld three cycles
    run_txn(SH, 32'h100, 32'h0000_ABCD, 32'd2, 32'h0, 5'd0, 1'b0, 32'h0, 3, 0);
    // Misaligned LW at ea 0x101
    run_txn(LW, 32'h100, 32'h0, 32'd1, 32'h0, 5'd9, 1'b1, 32'h0, 0, 0);
    // LH with a delayed response and negative half
    run_txn(LH, 32'h400, 32'h0, 32'd2, 32'h0, 5'd10, 1'b1, 32'h8001_7FFF, 1, 2);

    // Stray grant and rvalid while idle are ignored
    dmem_gnt_i    = 1'b1;
    dmem_rvalid_i = 1'b1;
    step();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    check("stray_valid", 32'(valid_o), 32'd0);
    check("stray_req", 32'(dmem_req_o), 32'd0);
    check("stray_stall", 32'(stall_o), 32'd0);

    // Reset in WAIT_RESP abandons the load; a later rvalid is dropped
    mem_bus_i.mem_op   = LW;
    mem_bus_i.rs1_data = 32'h300;
    mem_bus_i.imm      = 32'h0;
    mem_bus_i.rf_wr_en = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i    = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    check("rst_pre_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_wait");
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    step();
    dmem_rvalid_i = 1'b0;
    check("rst_stray_valid", 32'(valid_o), 32'd0);
    check("rst_stray_stall", 32'(stall_o), 32'd0);

    // Randomized transactions with random waits and idle gaps
    for (int n = 0; n < 120; n++) begin
      mem_op_e op;
      op = ops[$urandom_range(0, 8)];
      run_txn(op, $urandom, $urandom, 32'($urandom_range(0, 15)), $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        step();
        check("gap_valid", 32'(valid_o), 32'd0);
        check("gap_req", 32'(dmem_req_o), 32'd0);
        check("gap_mis", 32'(misaligned_o), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the ALU. Consumes the `core::pipeline_bus_t` produced by execute, computes load/store addresses, and drives a single-outstanding request/grant/response data-memory port. Formats load data (byte/half/word, sign/zero extension), stalls the front of the pipe while an access is in flight, and hands a registered bus to writeback. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters. Data and address widths are fixed at 32.
- `clk`  in  1  core clock. One clock domain only.
- `rst`  in  1  reset. Synchronous, active-high.
- `mem_bus_i`  in  `core::pipeline_bus_t`  bus from execute. Uses `rd_res`, `rs1_data`, `rs2_data`, `imm`, `mem_op`, `rd`, `rf_wr_en`.
- `valid_i`  in  1  `mem_bus_i` holds a live instruction.
- `stall_o`  out  1  stage busy. Upstream holds `mem_bus_i`/`valid_i` stable while high.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  32  word-aligned address, bits [1:0] = 0.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  store data, lane-shifted.
- `dmem_gnt_i`  in  1  request accepted this cycle.
- `dmem_rvalid_i`  in  1  load data valid.
- `dmem_rdata_i`  in  32  load data word.
- `mem_bus_o`  out  `core::pipeline_bus_t`  registered bus to writeback. `rd_res` holds the load result or the passed-through ALU result.
- `valid_o`  out  1  `mem_bus_o` live; one-cycle pulse per instruction.
- `misaligned_o`  out  1  one-cycle pulse on a misaligned access. Same cycle as `valid_o`.

## Operation
- Effective address: `ea = rs1_data + imm`, 32-bit wrap-around with no overflow check.
- Alignment check:
  - Half-word accesses are misaligned when `ea[0] = 1`.
  - Word accesses are misaligned when `ea[1:0] != 0`.
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE:
  - Input is sampled only in IDLE with `valid_i = 1`.
  - Non-memory op or MEM_NOP: register the bus, raise `valid_o` next cycle, stay in IDLE.
  - Aligned memory op: capture the bus, `ea`, `be` and shifted wdata; go to REQ.
  - Misaligned memory op: no request is issued. Next cycle `valid_o = 1`, `misaligned_o = 1` and `mem_bus_o.rf_wr_en = 0`; stay in IDLE.
- REQ:
  - `dmem_req_o = 1`; address, `be`, `we` and wdata are held stable until `dmem_gnt_i`.
  - On grant of a store: return to IDLE, `valid_o = 1` next cycle, `rf_wr_en = 0`.
  - On grant of a load: go to WAIT_RESP.
- WAIT_RESP:
  - On `dmem_rvalid_i`: select the byte/half at `ea[1:0]`, extend it, write it to `rd_res`, set `valid_o = 1` next cycle, return to IDLE.
- Byte enables:
  - SB: `0001 << ea[1:0]`.
  - SH: `0011 << ea[1:0]`.
  - SW: `1111`.
- Store wdata: the byte (SB) or half (SH) of `rs2_data` is replicated across all lanes.
- Load extension: LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
- `stall_o = (state != IDLE)`.
- Stray inputs are ignored: `dmem_rvalid_i` outside WAIT_RESP and `dmem_gnt_i` outside REQ.
- Reset values:
  - state = IDLE.
  - `dmem_req_o`, `dmem_we_o`, `valid_o`, `misaligned_o`, `stall_o` = 0.
  - `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o` = 0.
  - `mem_bus_o` all-zero.
- Reset during REQ or WAIT_RESP abandons the access. A later `dmem_rvalid_i` is dropped.

## Timing
- Cycle N is the cycle in which IDLE samples `valid_i`.
- ALU op: `valid_o` in N+1.
- Store, zero-wait grant: `dmem_req_o` in N+1, `valid_o` in N+2.
- Load, zero-wait grant and response: `dmem_req_o` in N+1, `rvalid` in N+2, `valid_o` in N+3.
- Each extra grant or response wait cycle adds one cycle of latency and one cycle of `stall_o`.
- Back-to-back throughput:
  - ALU ops: 1 per cycle.
  - Loads: 1 per 3 cycles at best.
  - Stores: 1 per 2 cycles at best.
- Grant and rvalid are never combined in a single cycle: a load needs at least one cycle in WAIT_RESP.

## Structure
- `core` package additions:
  - `mem_state_e` (IDLE/REQ/WAIT_RESP).
  - The load/store members of the existing `core::mem_op` enum (LB/LH/LW/LBU/LHU/SB/SH/SW) are reused as-is.
- Sub-module `load_formatter`: combinational extraction and extension from `{rdata, ea[1:0], mem_op}` to 32 bits. Reused by any future cache path.

## Test plan
- ADD pass-through: `valid_i` with `rd_res = 0x1234` → next cycle `valid_o = 1`, `mem_bus_o.rd_res = 0x1234`, no request.
- SW: `rs1 = 0x100`, `imm = 4`, `rs2 = 0xDEADBEEF`, grant immediately → `addr = 0x104`, `be = 1111`, `wdata = 0xDEADBEEF`, `valid_o` at N+2 with `rf_wr_en = 0`.
- LB sign-extension: `ea = 0x203`, `rdata = 0x80FF_0011` → `rd_res = 0xFFFFFF80`.
  - Same case as LBU → `rd_res = 0x00000080`.
- SH: `ea = 0x102`, `rs2 = 0x0000ABCD` → `be = 1100`, `wdata = 0xABCDABCD`.
  - Grant withheld for 3 cycles → `req`/`addr` stable and `stall_o = 1` throughout.
- Misaligned LW at `ea = 0x101` → no `dmem_req_o`, `valid_o` and `misaligned_o` in N+1, `rf_wr_en = 0`.
- `rst` asserted in WAIT_RESP:
  - Next cycle: state IDLE and all outputs 0.
  - A following stray `dmem_rvalid_i` → no `valid_o`.
